// File: rtl/sete_segmentos_mux_pkg.sv
// Shared segment patterns (active-low, bit6 = a .. bit0 = g) and the nibble decode
// function used by the multiplexed seven-segment display driver.
package sete_segmentos_mux_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Letters are only produced when hex_en is set; otherwise 10..15 render dark.
  function automatic logic [6:0] decode_nibble(input logic [3:0] nib, input logic hex_en);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = hex_en ? SEG_A : SEG_BLANK;
      4'hB:    pat = hex_en ? SEG_B : SEG_BLANK;
      4'hC:    pat = hex_en ? SEG_C : SEG_BLANK;
      4'hD:    pat = hex_en ? SEG_D : SEG_BLANK;
      4'hE:    pat = hex_en ? SEG_E : SEG_BLANK;
      default: pat = hex_en ? SEG_F : SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sete_segmentos_mux_if.sv
// Signal bundle of the display driver: load side (valor/pontos/apagar/carregar)
// and panel side (saida/saida_dp/anodo) plus status. carregar is a one-cycle strobe, no ready.
interface sete_segmentos_mux_if #(
  parameter int NUM_DIGITOS = 4
);
  logic [4*NUM_DIGITOS-1:0] valor;
  logic [NUM_DIGITOS-1:0]   pontos;
  logic [NUM_DIGITOS-1:0]   apagar;
  logic                     supressao_zeros;
  logic                     carregar;
  logic [6:0]               saida;
  logic                     saida_dp;
  logic [NUM_DIGITOS-1:0]   anodo;
  logic                     pendente;
  logic                     fim_quadro;

  modport master (
    output valor, pontos, apagar, supressao_zeros, carregar,
    input  saida, saida_dp, anodo, pendente, fim_quadro
  );

  modport slave (
    input  valor, pontos, apagar, supressao_zeros, carregar,
    output saida, saida_dp, anodo, pendente, fim_quadro
  );
endinterface

// File: rtl/sete_segmentos_decod.sv
// Combinational nibble -> segment pattern. Letters A..F appear only when the
// SETE_SEGMENTOS_HEX_EN macro is defined; otherwise 10..15 decode as blank.
module sete_segmentos_decod
  import sete_segmentos_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] padrao
);
`ifdef SETE_SEGMENTOS_HEX_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  assign padrao = decode_nibble(nibble, HEX_EN);
endmodule

// File: rtl/sete_segmentos_mux.sv
// Time-multiplexed seven-segment driver with frame-aligned value commit and
// leading-zero suppression. Hex letters enabled by SETE_SEGMENTOS_HEX_EN.
module sete_segmentos_mux
  import sete_segmentos_mux_pkg::*;
#(
  parameter int NUM_DIGITOS = 4,
  parameter int PRESCALE    = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4*NUM_DIGITOS-1:0] valor,
  input  logic [NUM_DIGITOS-1:0]   pontos,
  input  logic [NUM_DIGITOS-1:0]   apagar,
  input  logic                     supressao_zeros,
  input  logic                     carregar,
  output logic [6:0]               saida,
  output logic                     saida_dp,
  output logic [NUM_DIGITOS-1:0]   anodo,
  output logic                     pendente,
  output logic                     fim_quadro
);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITOS;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [VAL_W-1:0]       disp_valor_q, disp_valor_d, pend_valor_q, pend_valor_d;
  logic [NUM_DIGITOS-1:0] disp_pontos_q, disp_pontos_d, pend_pontos_q, pend_pontos_d;
  logic [NUM_DIGITOS-1:0] disp_apagar_q, disp_apagar_d, pend_apagar_q, pend_apagar_d;
  logic                   pendente_q, pendente_d;
  logic                   fim_quadro_q, fim_quadro_d;
  logic [6:0]             saida_q, saida_d;
  logic                   saida_dp_q, saida_dp_d;
  logic [NUM_DIGITOS-1:0] anodo_q, anodo_d;

  logic                   passo, wrap;
  logic [3:0]             nib_sel;
  logic                   ponto_sel, apagar_sel, suprimido;
  logic [IDX_W-1:0]       msd;
  logic [6:0]             padrao;

  // Scan timing and the pending/display double buffer: the display register
  // only changes on the wrap edge so a frame never mixes two values.
  always_comb begin
    passo         = (cnt_q == CNT_W'(PRESCALE - 1));
    wrap          = passo && (idx_q == IDX_W'(NUM_DIGITOS - 1));
    cnt_d         = passo ? '0 : cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    if (passo) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    disp_valor_d  = disp_valor_q;
    disp_pontos_d = disp_pontos_q;
    disp_apagar_d = disp_apagar_q;
    pend_valor_d  = pend_valor_q;
    pend_pontos_d = pend_pontos_q;
    pend_apagar_d = pend_apagar_q;
    pendente_d    = pendente_q;
    fim_quadro_d  = wrap;
    if (wrap) begin
      pendente_d = 1'b0;
      if (carregar) begin
        disp_valor_d  = valor;
        disp_pontos_d = pontos;
        disp_apagar_d = apagar;
      end else if (pendente_q) begin
        disp_valor_d  = pend_valor_q;
        disp_pontos_d = pend_pontos_q;
        disp_apagar_d = pend_apagar_q;
      end
    end else if (carregar) begin
      pend_valor_d  = valor;
      pend_pontos_d = pontos;
      pend_apagar_d = apagar;
      pendente_d    = 1'b1;
    end
  end

  // Digit selection; msd tracks the highest nonzero nibble (letters count as nonzero).
  always_comb begin
    nib_sel    = '0;
    ponto_sel  = 1'b0;
    apagar_sel = 1'b0;
    msd        = '0;
    anodo_d    = '1;
    for (int k = 0; k < NUM_DIGITOS; k++) begin
      if (disp_valor_q[4*k +: 4] != 4'h0) msd = IDX_W'(k);
      if (idx_q == IDX_W'(k)) begin
        nib_sel    = disp_valor_q[4*k +: 4];
        ponto_sel  = disp_pontos_q[k];
        apagar_sel = disp_apagar_q[k];
        anodo_d[k] = 1'b0;
      end
    end
    suprimido  = supressao_zeros && (idx_q > msd);
    saida_d    = (apagar_sel || suprimido) ? SEG_BLANK : padrao;
    saida_dp_d = (apagar_sel || suprimido) ? 1'b1 : ~ponto_sel;
  end

  sete_segmentos_decod u_decod (
    .nibble (nib_sel),
    .padrao (padrao)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      disp_valor_q  <= '0;
      disp_pontos_q <= '0;
      disp_apagar_q <= '0;
      pend_valor_q  <= '0;
      pend_pontos_q <= '0;
      pend_apagar_q <= '0;
      pendente_q    <= 1'b0;
      fim_quadro_q  <= 1'b0;
      saida_q       <= SEG_BLANK;
      saida_dp_q    <= 1'b1;
      anodo_q       <= '1;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      disp_valor_q  <= disp_valor_d;
      disp_pontos_q <= disp_pontos_d;
      disp_apagar_q <= disp_apagar_d;
      pend_valor_q  <= pend_valor_d;
      pend_pontos_q <= pend_pontos_d;
      pend_apagar_q <= pend_apagar_d;
      pendente_q    <= pendente_d;
      fim_quadro_q  <= fim_quadro_d;
      saida_q       <= saida_d;
      saida_dp_q    <= saida_dp_d;
      anodo_q       <= anodo_d;
    end
  end

  assign saida      = saida_q;
  assign saida_dp   = saida_dp_q;
  assign anodo      = anodo_q;
  assign pendente   = pendente_q;
  assign fim_quadro = fim_quadro_q;
endmodule
